seg7_mmio: RTL and testbench



---
 rtl/seg7_pkg.sv | 26 ++
 rtl/seg7_hex_decode.sv | 13 +
 rtl/seg7_mmio.sv | 124 ++++++++++++
 tb/tb_seg7_mmio.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared register map, control bit positions and hex font for the
// two-digit seven-segment MMIO controller.
package seg7_pkg;

    localparam logic [3:0] REG_DATA   = 4'h0;
    localparam logic [3:0] REG_CTRL   = 4'h4;
    localparam logic [3:0] REG_STATUS = 4'h8;

    localparam int unsigned CTRL_EN  = 0;
    localparam int unsigned CTRL_RAW = 1;

    // Implemented DATA bits: nibbles, decimal points, two 7-bit raw patterns
    localparam logic [31:0] DATA_MASK = 32'h7F7F_03FF;

    typedef enum logic {
        DIG0 = 1'b0,
        DIG1 = 1'b1
    } digit_e;

    // Segments {g,f,e,d,c,b,a}, active-high; entry 0 is the rightmost element
    localparam logic [15:0][6:0] HEX_FONT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to seven-segment pattern (active-high a..g).
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = HEX_FONT[nibble];
    end

endmodule

// File: rtl/seg7_mmio.sv
// Memory-mapped two-digit seven-segment controller on the picorv32 native bus;
// scans both commons with a blanking gap at the start of every digit slot.
module seg7_mmio
    import seg7_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 125000000,
    parameter int unsigned SCAN_HZ        = 1000,
    parameter int unsigned BLANK_CYCLES   = 16,
    parameter logic [31:0] BASE_ADDR      = 32'h0300_0000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          COM_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic [7:0]  SEG_o,
    output logic [1:0]  COM_o
);

    localparam int unsigned DIG_CYCLES = CLK_HZ / (SCAN_HZ * 2);
    localparam int unsigned PW         = $clog2(DIG_CYCLES);
    localparam logic [PW-1:0] PRESC_LAST  = PW'(DIG_CYCLES - 1);
    localparam logic [PW-1:0] PRESC_BLANK = PW'(BLANK_CYCLES);
    localparam logic [7:0] SEG_OFF = {8{SEG_ACTIVE_LOW}};
    localparam logic [1:0] COM_OFF = {2{COM_ACTIVE_LOW}};

    logic          sel, acc, wr, ctrl_wr, en_clear;
    logic [3:0]    reg_off;
    logic [31:0]   data_q, data_merged, rd_val;
    logic [1:0]    ctrl_q;
    logic [PW-1:0] presc;
    digit_e        digit;
    logic          blanking, lit;
    logic [3:0]    nibble;
    logic [6:0]    font_seg, pat;
    logic [7:0]    seg_nxt;
    logic [1:0]    com_nxt;

    seg7_hex_decode u_hex (
        .nibble (nibble),
        .seg    (font_seg)
    );

    always_comb begin
        reg_off  = mem_addr[3:0];
        sel      = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]);
        acc      = sel && !mem_ready;
        wr       = acc && (|mem_wstrb);
        ctrl_wr  = wr && (reg_off == REG_CTRL) && mem_wstrb[0];
        // A write clearing EN overrides a digit wrap landing on the same edge
        en_clear = !ctrl_q[CTRL_EN] || (ctrl_wr && !mem_wdata[CTRL_EN]);
        for (int unsigned b = 0; b < 4; b++) begin
            data_merged[8*b +: 8] = mem_wstrb[b] ? mem_wdata[8*b +: 8] : data_q[8*b +: 8];
        end
        blanking = ctrl_q[CTRL_EN] && (presc < PRESC_BLANK);
        lit      = ctrl_q[CTRL_EN] && !(presc < PRESC_BLANK);
        case (reg_off)
            REG_DATA:   rd_val = data_q;
            REG_CTRL:   rd_val = {30'b0, ctrl_q};
            REG_STATUS: rd_val = {30'b0, blanking, logic'(digit)};
            default:    rd_val = '0;
        endcase
    end

    always_comb begin
        nibble = (digit == DIG0) ? data_q[3:0] : data_q[7:4];
        if (ctrl_q[CTRL_RAW]) begin
            pat = (digit == DIG0) ? data_q[22:16] : data_q[30:24];
        end else begin
            pat = font_seg;
        end
        seg_nxt = '0;
        com_nxt = '0;
        if (lit) begin
            seg_nxt = {(digit == DIG0) ? data_q[8] : data_q[9], pat};
            com_nxt = (digit == DIG0) ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            data_q    <= '0;
            ctrl_q    <= '0;
        end else begin
            mem_ready <= acc;
            mem_rdata <= (acc && mem_wstrb == 4'h0) ? rd_val : '0;
            if (wr && reg_off == REG_DATA) begin
                data_q <= data_merged & DATA_MASK;
            end
            if (ctrl_wr) begin
                ctrl_q <= mem_wdata[1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            presc <= '0;
            digit <= DIG0;
            SEG_o <= SEG_OFF;
            COM_o <= COM_OFF;
        end else begin
            if (en_clear) begin
                presc <= '0;
                digit <= DIG0;
            end else if (presc == PRESC_LAST) begin
                presc <= '0;
                digit <= (digit == DIG0) ? DIG1 : DIG0;
            end else begin
                presc <= presc + 1'b1;
            end
            SEG_o <= seg_nxt ^ SEG_OFF;
            COM_o <= com_nxt ^ COM_OFF;
        end
    end

endmodule

// File: tb/tb_seg7_mmio.sv
// Scoreboard bench for seg7_mmio: bus responses checked by a monitor, pins by directed scans.
module tb_seg7_mmio;

    localparam logic [31:0] BASE = 32'h0300_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [7:0]  SEG_o;
    logic [1:0]  COM_o;

    typedef struct {
        bit          is_read;
        logic [31:0] exp;
        string       name;
    } txn_t;

    txn_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    seg7_mmio #(
        .CLK_HZ       (1000),
        .SCAN_HZ      (100),
        .BLANK_CYCLES (1)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .SEG_o     (SEG_o),
        .COM_o     (COM_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic pins(input string name, input logic [1:0] com, input logic [7:0] seg);
        check({name, " COM_o"}, {30'b0, COM_o}, {30'b0, com});
        check({name, " SEG_o"}, {24'b0, SEG_o}, {24'b0, seg});
    endtask

    // Starts at a negedge, returns at the negedge after the ready pulse
    task automatic bus(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input logic [31:0] exp, input string name);
        int unsigned waited = 0;
        sb.push_back('{wstrb == 4'h0, exp, name});
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        mem_valid = 1'b1;
        do begin
            @(negedge clk);
            waited++;
        end while (!mem_ready && waited < 8);
        check({name, " ready latency"}, waited, 1);
        mem_valid = 1'b0;
        mem_wstrb = '0;
        @(negedge clk);
        check({name, " ready single pulse"}, {31'b0, mem_ready}, 0);
    endtask

    // Called right after the enabling CTRL write returns
    task automatic check_scan(input string name, input logic [7:0] seg0, input logic [7:0] seg1);
        for (int i = 0; i < 20; i++) begin
            int p;
            @(negedge clk);
            p = (i + 1) % 10;
            if (p == 0 || p == 5)  pins({name, " blank"}, 2'b11, 8'hFF);
            else if (p < 5)        pins({name, " digit0"}, 2'b10, seg0);
            else                   pins({name, " digit1"}, 2'b01, seg1);
        end
    endtask

    always @(negedge clk) begin
        txn_t t;
        if (resetn) begin
            check("commons exclusive", {31'b0, COM_o == 2'b00}, 0);
            if (mem_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected ready", {31'b0, mem_ready}, 0);
                end else begin
                    t = sb.pop_front();
                    if (t.is_read) check(t.name, mem_rdata, t.exp);
                end
            end else begin
                check("rdata idle", mem_rdata, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        pins("in reset", 2'b11, 8'hFF);
        check("in reset ready", {31'b0, mem_ready}, 0);
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            pins("idle", 2'b11, 8'hFF);
            check("idle ready", {31'b0, mem_ready}, 0);
        end

        bus(BASE + 32'h0, 32'h0000_00A5, 4'hF, 0, "wr DATA A5");
        bus(BASE + 32'h0, 0, 4'h0, 32'h0000_00A5, "rd DATA A5");

        bus(BASE + 32'h4, 32'h1, 4'hF, 0, "wr CTRL en");
        check_scan("hex A5", ~8'h6D, ~8'h77);
        bus(BASE + 32'h4, 0, 4'h0, 32'h1, "rd CTRL 1");

        bus(BASE + 32'h0, 32'hFFFF_FFFF, 4'b0001, 0, "wr DATA byte0");
        bus(BASE + 32'h0, 0, 4'h0, 32'h0000_00FF, "rd DATA byte0");
        bus(BASE + 32'h4, 32'h0, 4'hF, 0, "wr CTRL off");
        bus(BASE + 32'h4, 32'h1, 4'hF, 0, "wr CTRL en");
        check_scan("hex FF", ~8'h71, ~8'h71);

        bus(BASE + 32'h0, 32'h0049_0136, 4'hF, 0, "wr DATA raw");
        bus(BASE + 32'h0, 0, 4'h0, 32'h0049_0136, "rd DATA raw");
        bus(BASE + 32'h4, 32'h0, 4'hF, 0, "wr CTRL off");
        bus(BASE + 32'h4, 32'h3, 4'hF, 0, "wr CTRL raw");
        check_scan("raw dp", ~8'hC9, ~8'h00);

        // Disable while digit1 is lit
        bus(BASE + 32'h4, 32'h0, 4'hF, 0, "wr CTRL off");
        bus(BASE + 32'h4, 32'h3, 4'hF, 0, "wr CTRL raw");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0 || i == 5) begin
                if (i == 0) pins("pre-disable d0", 2'b10, ~8'hC9);
                else        pins("pre-disable d1", 2'b01, ~8'h00);
            end
        end
        bus(BASE + 32'h4, 32'h0, 4'hF, 0, "wr CTRL disable");
        pins("after disable", 2'b11, 8'hFF);
        bus(BASE + 32'h8, 0, 4'h0, 32'h0, "rd STATUS disabled");
        bus(BASE + 32'h4, 32'h1, 4'hF, 0, "wr CTRL reenable");
        check_scan("hex dp 36", ~8'hFD, ~8'h4F);

        // STATUS at the blank slot of digit1
        bus(BASE + 32'h4, 32'h0, 4'hF, 0, "wr CTRL off");
        bus(BASE + 32'h4, 32'h1, 4'hF, 0, "wr CTRL en");
        repeat (4) @(negedge clk);
        bus(BASE + 32'h8, 0, 4'h0, 32'h3, "rd STATUS d1 blank");

        bus(BASE + 32'h4, 32'h0, 4'hF, 0, "wr CTRL off");
        bus(BASE + 32'h8, 32'hFFFF_FFFF, 4'hF, 0, "wr STATUS");
        bus(BASE + 32'h8, 0, 4'h0, 32'h0, "rd STATUS ro");
        bus(BASE + 32'h4, 0, 4'h0, 32'h0, "rd CTRL 0");
        bus(BASE + 32'hC, 0, 4'h0, 32'h0, "rd reserved");

        mem_addr  = BASE + 32'h10;
        mem_wdata = 32'hDEAD_BEEF;
        mem_wstrb = 4'hF;
        mem_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("unmapped no ready", {31'b0, mem_ready}, 0);
        end
        mem_valid = 1'b0;
        mem_wstrb = '0;
        @(negedge clk);
        bus(BASE + 32'h0, 0, 4'h0, 32'h0049_0136, "rd DATA after unmapped");

        bus(BASE + 32'h4, 32'h1, 4'hF, 0, "wr CTRL en");
        mem_addr  = BASE;
        mem_wdata = 32'h0000_0055;
        mem_wstrb = 4'hF;
        mem_valid = 1'b1;
        @(posedge clk);
        #1 resetn = 1'b0;
        #1;
        check("reset drops ready", {31'b0, mem_ready}, 0);
        pins("reset mid-access", 2'b11, 8'hFF);
        mem_valid = 1'b0;
        mem_wstrb = '0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        bus(BASE + 32'h0, 0, 4'h0, 32'h0, "rd DATA after reset");
        bus(BASE + 32'h4, 0, 4'h0, 32'h0, "rd CTRL after reset");

        @(negedge clk);
        check("scoreboard drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
